// File: rtl/stopwatch_run_controller.sv
// stopwatch_run_controller: run/pause/lap/clear sequencer for the stopwatch counter.
// Produces the prescaled count_enable tick, the latched count direction and load
// strobes. In count-down mode it stops at zero and raises expired. In count-up mode
// it stops when every digit reads 9.
// Optional feature macro: STOPWATCH_LAP_EN (lap capture register; absent by default).
module stopwatch_run_controller #(
  parameter int unsigned NUMBER_OF_DIGITS            = 4,
  parameter int unsigned NUMBER_OF_BITS_PER_DIGIT    = 4,
  parameter int unsigned BOARD_CLOCK_FREQUENCY_IN_HZ = 100_000_000,
  parameter int unsigned TICK_RATE_IN_HZ             = 100,
  localparam int unsigned W = NUMBER_OF_DIGITS * NUMBER_OF_BITS_PER_DIGIT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         btn_start,
  input  logic         btn_lap,
  input  logic         btn_clear,
  input  logic         mode_down,
  input  logic [W-1:0] preset_value,
  input  logic [W-1:0] count_value,
  output logic         count_enable,
  output logic         count_up_down,
  output logic         count_load,
  output logic [W-1:0] load_value,
  output logic [W-1:0] lap_value,
  output logic         lap_valid,
  output logic         expired,
  output logic [1:0]   state
);

  localparam int unsigned DIV = BOARD_CLOCK_FREQUENCY_IN_HZ / TICK_RATE_IN_HZ;
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic           all_nines, at_limit, tick;
  logic           enable_d, load_d, up_down_d;
  logic [W-1:0]   load_value_d, load_sel;

`ifdef STOPWATCH_LAP_EN
  logic           lap_valid_d;
  logic [W-1:0]   lap_value_d;
`else
  logic           unused_btn_lap;
  assign unused_btn_lap = btn_lap;
  assign lap_value      = '0;
  assign lap_valid      = 1'b0;
`endif

  // Up-mode terminal value: every BCD digit equals 9
  always_comb begin
    all_nines = 1'b1;
    for (int unsigned i = 0; i < NUMBER_OF_DIGITS; i++) begin
      if (count_value[i*NUMBER_OF_BITS_PER_DIGIT +: NUMBER_OF_BITS_PER_DIGIT] !=
          NUMBER_OF_BITS_PER_DIGIT'(9))
        all_nines = 1'b0;
    end
  end

  // Limit check uses the direction latched at start, not the live mode_down level
  assign at_limit = count_up_down ? (count_value == '0) : all_nines;
  assign tick     = (state_q == RUNNING) && (presc_q == PRESC_LAST);
  assign load_sel = mode_down ? preset_value : '0;

  assign expired = (state_q == EXPIRED);
  assign state   = state_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; priority clear > start > tick
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!btn_clear && btn_start) state_d = RUNNING;
      RUNNING: begin
        if (btn_clear)             state_d = IDLE;
        else if (btn_start)        state_d = PAUSED;
        else if (tick && at_limit) state_d = EXPIRED;
      end
      PAUSED: begin
        if (btn_clear)      state_d = IDLE;
        else if (btn_start) state_d = RUNNING;
      end
      EXPIRED: if (btn_clear) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs and the prescaler
  always_comb begin
    enable_d     = 1'b0;
    load_d       = 1'b0;
    up_down_d    = count_up_down;
    load_value_d = load_value;
    presc_d      = presc_q;
`ifdef STOPWATCH_LAP_EN
    lap_valid_d  = 1'b0;
    lap_value_d  = lap_value;
`endif
    if (btn_clear) begin
      load_d       = 1'b1;
      load_value_d = load_sel;
      presc_d      = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (btn_start) begin
            load_d       = 1'b1;
            load_value_d = load_sel;
            up_down_d    = mode_down;
            presc_d      = '0;
          end
        end
        RUNNING: begin
          // Prescaler advances on every running cycle, including the pausing one,
          // so a resume continues from the value after that cycle
          presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
          if (!btn_start) begin
            if (tick && !at_limit) enable_d = 1'b1;
`ifdef STOPWATCH_LAP_EN
            if (btn_lap) begin
              lap_valid_d = 1'b1;
              lap_value_d = count_value;
            end
`endif
          end
        end
        default: ;
      endcase
    end
  end

  // Output and prescaler registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q       <= '0;
      count_enable  <= 1'b0;
      count_load    <= 1'b0;
      count_up_down <= 1'b0;
      load_value    <= '0;
`ifdef STOPWATCH_LAP_EN
      lap_valid     <= 1'b0;
      lap_value     <= '0;
`endif
    end else begin
      presc_q       <= presc_d;
      count_enable  <= enable_d;
      count_load    <= load_d;
      count_up_down <= up_down_d;
      load_value    <= load_value_d;
`ifdef STOPWATCH_LAP_EN
      lap_valid     <= lap_valid_d;
      lap_value     <= lap_value_d;
`endif
    end
  end

endmodule
